hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the five-stage MIPS core.
- Combines pre-decoded register-use information from D with destination and Tnew information from E and M.
- Tracks the multiply/divide unit's busy window.
- Drives the freeze of PC and F/D and the bubble insertion (`clr`) into the D/E pipeline register; M/W and E/M never stall.
- Keeps a saturating stall-cycle counter for performance statistics.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/hazard_ctrl_if.sv | 33 +++
 rtl/md_busy_timer.sv | 34 +++
 rtl/hazard_ctrl.sv | 55 +++++
 tb/tb_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the five-stage MIPS core: Tuse/Tnew encodings, register
// indices, multiply/divide latencies and the register-hazard predicate.
package mips_pkg;

  localparam logic [1:0]  TUSE_NONE       = 2'd3;
  localparam logic [4:0]  REG_ZERO        = 5'd0;
  localparam int          MULT_CYCLES_DEF = 5;
  localparam int          DIV_CYCLES_DEF  = 10;
  localparam logic [31:0] STALL_CNT_MAX   = 32'hFFFF_FFFF;

  // A D-stage source stalls when a younger-needed value is still in flight in E or M.
  function automatic logic reg_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] dst_e,
    input logic [1:0] tnew_e,
    input logic [4:0] dst_m,
    input logic [1:0] tnew_m
  );
    return (src != REG_ZERO) && (tuse != TUSE_NONE) &&
           (((src == dst_e) && (tuse < tnew_e)) ||
            ((src == dst_m) && (tuse < tnew_m)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/execute hazard information into the controller and stall controls out.
interface hazard_ctrl_if;
  import mips_pkg::*;

  logic [4:0]  rs_D;
  logic [4:0]  rt_D;
  logic [1:0]  tuse_rs_D;
  logic [1:0]  tuse_rt_D;
  logic [4:0]  dst_E;
  logic [4:0]  dst_M;
  logic [1:0]  tnew_E;
  logic [1:0]  tnew_M;
  logic        md_start_E;
  logic        md_is_div_E;
  logic        md_use_D;
  logic        stall;
  logic        clr_E;
  logic        md_busy;
  logic [31:0] stall_cnt;

  modport master (
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D, dst_E, dst_M, tnew_E, tnew_M,
           md_start_E, md_is_div_E, md_use_D,
    input  stall, clr_E, md_busy, stall_cnt
  );

  modport slave (
    input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, dst_E, dst_M, tnew_E, tnew_M,
           md_start_E, md_is_div_E, md_use_D,
    output stall, clr_E, md_busy, stall_cnt
  );

endinterface

// File: rtl/md_busy_timer.sv
// HI/LO unit busy window: loads the operation latency when a mult/div leaves E,
// then counts down to idle. A new start reloads rather than accumulates.
module md_busy_timer
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] r_busy_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy_cnt <= '0;
    end else if (start) begin
      r_busy_cnt <= is_div ? DIV_LOAD : MULT_LOAD;
    end else if (r_busy_cnt != '0) begin
      r_busy_cnt <= r_busy_cnt - 1'b1;
    end
  end

  assign busy = (r_busy_cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freezes PC and F/D, bubbles D/E, tracks the
// multiply/divide busy window and keeps a saturating stall-cycle count.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input logic        clk,
  input logic        clr,
  hazard_ctrl_if.slave hz
);

  logic        w_stall_rs;
  logic        w_stall_rt;
  logic        w_stall_md;
  logic        w_stall;
  logic        w_md_busy;
  logic [31:0] r_stall_cnt;

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_timer (
    .clk    (clk),
    .rst    (clr),
    .start  (hz.md_start_E),
    .is_div (hz.md_is_div_E),
    .busy   (w_md_busy)
  );

  assign w_stall_rs = reg_hazard(hz.rs_D, hz.tuse_rs_D, hz.dst_E, hz.tnew_E,
                                 hz.dst_M, hz.tnew_M);
  assign w_stall_rt = reg_hazard(hz.rt_D, hz.tuse_rt_D, hz.dst_E, hz.tnew_E,
                                 hz.dst_M, hz.tnew_M);
  // A starting mult/div is not yet counted as busy, so catch it directly.
  assign w_stall_md = hz.md_use_D && (w_md_busy || hz.md_start_E);
  assign w_stall    = w_stall_rs | w_stall_rt | w_stall_md;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != STALL_CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign hz.stall     = w_stall;
  assign hz.clr_E     = w_stall;
  assign hz.md_busy   = w_md_busy;
  assign hz.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: load-use, zero register,
// multiply/divide windows, async clear, stall overlap and counter saturation.
module tb_hazard_ctrl;
  import mips_pkg::*;

  logic clk;
  logic clr;
  int   total;
  int   bad;

  hazard_ctrl_if hz ();

  hazard_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk (clk),
    .clr (clr),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    hz.rs_D        = 5'd0;
    hz.rt_D        = 5'd0;
    hz.tuse_rs_D   = TUSE_NONE;
    hz.tuse_rt_D   = TUSE_NONE;
    hz.dst_E       = 5'd0;
    hz.dst_M       = 5'd0;
    hz.tnew_E      = 2'd0;
    hz.tnew_M      = 2'd0;
    hz.md_start_E  = 1'b0;
    hz.md_is_div_E = 1'b0;
    hz.md_use_D    = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    clear_inputs();
    repeat (3) @(negedge clk);
    #1;
    total++; if (hz.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", hz.stall); end
    total++; if (hz.clr_E !== 1'b0) begin bad++; $display("FAIL reset_clr_E got=%b exp=0", hz.clr_E); end
    total++; if (hz.md_busy !== 1'b0) begin bad++; $display("FAIL reset_md_busy got=%b exp=0", hz.md_busy); end
    total++; if (hz.stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d exp=0", hz.stall_cnt); end
    clr = 1'b0;
    $display("reset: stall=%b md_busy=%b stall_cnt=%0d", hz.stall, hz.md_busy, hz.stall_cnt);
  endtask

  task automatic test_load_use();
    // lw in E, consumer needs rs immediately
    @(negedge clk);
    hz.dst_E = 5'd8; hz.tnew_E = 2'd2; hz.rs_D = 5'd8; hz.tuse_rs_D = 2'd0;
    #1;
    total++; if (hz.stall !== 1'b1) begin bad++; $display("FAIL load_use_stall got=%b exp=1", hz.stall); end
    total++; if (hz.clr_E !== 1'b1) begin bad++; $display("FAIL load_use_clr_E got=%b exp=1", hz.clr_E); end
    $display("load_use tuse=0: stall=%b clr_E=%b", hz.stall, hz.clr_E);
    hz.tuse_rs_D = 2'd2;
    #1;
    total++; if (hz.stall !== 1'b0) begin bad++; $display("FAIL load_use_late_tuse got=%b exp=0", hz.stall); end
    $display("load_use tuse=2: stall=%b", hz.stall);
    clear_inputs();
    // M-stage producer on rt, one cycle outstanding
    @(negedge clk);
    hz.dst_M = 5'd9; hz.tnew_M = 2'd1; hz.rt_D = 5'd9; hz.tuse_rt_D = 2'd0;
    #1;
    total++; if (hz.stall !== 1'b1) begin bad++; $display("FAIL m_rt_stall got=%b exp=1", hz.stall); end
    $display("m_rt tuse=0 tnew=1: stall=%b", hz.stall);
    hz.tnew_M = 2'd3; hz.tuse_rt_D = TUSE_NONE;
    #1;
    total++; if (hz.stall !== 1'b0) begin bad++; $display("FAIL tuse_none got=%b exp=0", hz.stall); end
    $display("m_rt tuse=3 tnew=3: stall=%b", hz.stall);
    clear_inputs();
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    hz.rs_D = 5'd0; hz.dst_E = 5'd0; hz.tnew_E = 2'd2; hz.tuse_rs_D = 2'd0;
    hz.rt_D = 5'd0; hz.dst_M = 5'd0; hz.tnew_M = 2'd3; hz.tuse_rt_D = 2'd0;
    #1;
    total++; if (hz.stall !== 1'b0) begin bad++; $display("FAIL zero_reg got=%b exp=0", hz.stall); end
    $display("zero_reg: stall=%b", hz.stall);
    clear_inputs();
  endtask

  task automatic test_mult();
    @(negedge clk);
    hz.md_start_E = 1'b1; hz.md_is_div_E = 1'b0; hz.md_use_D = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      #1;
      total++; if (hz.stall !== (c <= 5)) begin bad++; $display("FAIL mult_stall c=%0d got=%b exp=%b", c, hz.stall, (c <= 5)); end
      total++; if (hz.md_busy !== (c >= 1 && c <= 5)) begin bad++; $display("FAIL mult_busy c=%0d got=%b exp=%b", c, hz.md_busy, (c >= 1 && c <= 5)); end
      $display("mult cycle t+%0d: stall=%b md_busy=%b", c, hz.stall, hz.md_busy);
      if (c < 6) begin
        @(negedge clk);
        hz.md_start_E = 1'b0;
      end
    end
    total++; if (hz.stall_cnt !== 32'd6) begin bad++; $display("FAIL mult_stall_cnt got=%0d exp=6", hz.stall_cnt); end
    clear_inputs();
  endtask

  task automatic test_div();
    int n;
    @(negedge clk);
    hz.md_start_E = 1'b1; hz.md_is_div_E = 1'b1;
    @(negedge clk);
    hz.md_start_E = 1'b0; hz.md_is_div_E = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!hz.md_busy) break;
      n++;
      @(negedge clk);
    end
    total++; if (n !== 10) begin bad++; $display("FAIL div_busy_len got=%0d exp=10", n); end
    $display("div: busy cycles=%0d", n);
    // second div arrives while 7 cycles remain
    @(negedge clk);
    hz.md_start_E = 1'b1; hz.md_is_div_E = 1'b1;
    @(negedge clk);
    hz.md_start_E = 1'b0; hz.md_is_div_E = 1'b0;
    repeat (3) @(negedge clk);
    hz.md_start_E = 1'b1; hz.md_is_div_E = 1'b1;
    #1;
    total++; if (hz.md_busy !== 1'b1) begin bad++; $display("FAIL div_busy_before_reload got=%b exp=1", hz.md_busy); end
    @(negedge clk);
    hz.md_start_E = 1'b0; hz.md_is_div_E = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!hz.md_busy) break;
      n++;
      @(negedge clk);
    end
    total++; if (n !== 10) begin bad++; $display("FAIL div_reload_len got=%0d exp=10", n); end
    $display("div reload: busy cycles after reload=%0d", n);
    clear_inputs();
  endtask

  task automatic test_clr_mid();
    int n;
    @(negedge clk);
    hz.md_start_E = 1'b1; hz.md_is_div_E = 1'b1; hz.md_use_D = 1'b1;
    @(negedge clk);
    hz.md_start_E = 1'b0; hz.md_is_div_E = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    total++; if (hz.md_busy !== 1'b1) begin bad++; $display("FAIL clr_pre_busy got=%b exp=1", hz.md_busy); end
    total++; if (hz.stall_cnt !== 32'd11) begin bad++; $display("FAIL clr_pre_stall_cnt got=%0d exp=11", hz.stall_cnt); end
    clr = 1'b1;
    #1;
    total++; if (hz.md_busy !== 1'b0) begin bad++; $display("FAIL clr_busy got=%b exp=0", hz.md_busy); end
    total++; if (hz.stall_cnt !== 32'd0) begin bad++; $display("FAIL clr_stall_cnt got=%0d exp=0", hz.stall_cnt); end
    total++; if (hz.stall !== 1'b0) begin bad++; $display("FAIL clr_stall got=%b exp=0", hz.stall); end
    $display("clr mid-div: md_busy=%b stall_cnt=%0d", hz.md_busy, hz.stall_cnt);
    #1;
    clr = 1'b0;
    clear_inputs();
    @(negedge clk);
    hz.md_start_E = 1'b1; hz.md_is_div_E = 1'b0;
    @(negedge clk);
    hz.md_start_E = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!hz.md_busy) break;
      n++;
      @(negedge clk);
    end
    total++; if (n !== 5) begin bad++; $display("FAIL clr_resume_len got=%0d exp=5", n); end
    total++; if (hz.stall_cnt !== 32'd0) begin bad++; $display("FAIL clr_resume_cnt got=%0d exp=0", hz.stall_cnt); end
    $display("after clr: mult busy cycles=%0d stall_cnt=%0d", n, hz.stall_cnt);
    clear_inputs();
  endtask

  task automatic test_overlap();
    @(negedge clk);
    hz.md_start_E = 1'b1; hz.md_is_div_E = 1'b0; hz.md_use_D = 1'b1;
    hz.rt_D = 5'd5; hz.tuse_rt_D = 2'd0; hz.dst_E = 5'd5; hz.tnew_E = 2'd1;
    for (int i = 0; i < 7; i++) begin
      #1;
      total++; if (hz.stall !== 1'b1) begin bad++; $display("FAIL overlap_stall i=%0d got=%b exp=1", i, hz.stall); end
      @(negedge clk);
      hz.md_start_E = 1'b0;
    end
    clear_inputs();
    #1;
    total++; if (hz.stall_cnt !== 32'd7) begin bad++; $display("FAIL overlap_cnt got=%0d exp=7", hz.stall_cnt); end
    $display("overlap: stall_cnt=%0d", hz.stall_cnt);
    repeat (6) @(negedge clk);
  endtask

  task automatic test_saturate();
    logic [31:0] exp_cnt [4];
    exp_cnt[0] = 32'hFFFF_FFFE;
    exp_cnt[1] = 32'hFFFF_FFFF;
    exp_cnt[2] = 32'hFFFF_FFFF;
    exp_cnt[3] = 32'hFFFF_FFFF;
    @(negedge clk);
    dut.r_stall_cnt = 32'hFFFF_FFFD;
    hz.dst_E = 5'd8; hz.tnew_E = 2'd2; hz.rs_D = 5'd8; hz.tuse_rs_D = 2'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      total++; if (hz.stall_cnt !== exp_cnt[i]) begin bad++; $display("FAIL saturate i=%0d got=%h exp=%h", i, hz.stall_cnt, exp_cnt[i]); end
      $display("saturate step %0d: stall_cnt=%h", i, hz.stall_cnt);
    end
    clear_inputs();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_mult();
    test_div();
    test_clr_mid();
    test_overlap();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
